alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue/retire sequencer between a small register file and an external ALU
//
// Accepts one 16-bit instruction at a time, gates it on a condition code,
// issues operands to an external combinational ALU for one cycle, then
// retires the captured result into the register file and status register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake, in_instr fields:
//                            [15:12] mode [11:9] rd [8:6] ra [5:3] rb [2] wb [1:0] cond
//   wr_en/wr_addr/wr_data    host register-file write port (honoured only when idle)
//   dbg_addr/dbg_data        combinational register read-back
//   alu_op1/op2/mode/en      operands and control to the external ALU
//   alu_cflags               current status register fed to the ALU
//   alu_out/alu_flags        ALU result and {Z,C,S,O} flags
//   done/skipped/res_data    one-cycle retire pulse and its result
//   status                   status register {Z,C,S,O}

module alu_issue_unit #(
  parameter logic [3:0] RST_STATUS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [15:0] in_instr,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic [3:0] alu_mode,
  output logic       alu_en,
  output logic [3:0] alu_cflags,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic       done,
  output logic       skipped,
  output logic [7:0] res_data,
  output logic [3:0] status
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2,
    SKIP  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [7:0] r_regs [0:7];
  logic [3:0] r_status;

  logic [3:0] r_mode;
  logic [2:0] r_rd;
  logic [2:0] r_ra;
  logic [2:0] r_rb;
  logic       r_wb;
  logic [7:0] r_res;
  logic [3:0] r_flags;

  logic       w_idle;
  logic       w_accept;
  logic       w_cond_true;
  logic       w_host_wr;
  logic       w_writeback;
  logic [7:0] w_op1;
  logic [7:0] w_op2;

  assign w_idle      = (r_state == IDLE);
  assign w_accept    = in_valid & w_idle & ~rst;
  assign w_host_wr   = wr_en & w_idle & (wr_addr != 3'd0);
  assign w_writeback = (r_state == WRITE) & r_wb & (r_rd != 3'd0);

  // R0 is hard-wired to zero on every read path.
  assign w_op1    = (r_ra == 3'd0) ? 8'h00 : r_regs[r_ra];
  assign w_op2    = (r_rb == 3'd0) ? 8'h00 : r_regs[r_rb];
  assign dbg_data = (dbg_addr == 3'd0) ? 8'h00 : r_regs[dbg_addr];

  assign status     = r_status;
  assign alu_cflags = r_status;

  // Condition is judged against the status visible in the accept cycle.
  always_comb begin
    w_cond_true = 1'b0;
    case (in_instr[1:0])
      2'b00:   w_cond_true = 1'b1;
      2'b01:   w_cond_true = r_status[3];
      2'b10:   w_cond_true = r_status[2];
      default: w_cond_true = r_status[1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    alu_en       = 1'b0;
    alu_mode     = 4'h0;
    alu_op1      = 8'h00;
    alu_op2      = 8'h00;
    done         = 1'b0;
    skipped      = 1'b0;
    res_data     = 8'h00;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = w_cond_true ? ISSUE : SKIP;
        end
      end
      ISSUE: begin
        alu_en       = 1'b1;
        alu_mode     = r_mode;
        alu_op1      = w_op1;
        alu_op2      = w_op2;
        w_next_state = WRITE;
      end
      WRITE: begin
        done         = 1'b1;
        res_data     = r_res;
        w_next_state = IDLE;
      end
      SKIP: begin
        done         = 1'b1;
        skipped      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // A retire that coincides with reset is discarded, so it must not be announced.
    if (rst) begin
      done     = 1'b0;
      skipped  = 1'b0;
      res_data = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_status <= RST_STATUS;
      r_mode   <= 4'h0;
      r_rd     <= 3'd0;
      r_ra     <= 3'd0;
      r_rb     <= 3'd0;
      r_wb     <= 1'b0;
      r_res    <= 8'h00;
      r_flags  <= 4'h0;
    end else begin
      // Host write and instruction retire never share a cycle: host writes
      // are honoured only in IDLE, retire happens only in WRITE.
      if (w_host_wr) begin
        r_regs[wr_addr] <= wr_data;
      end
      if (w_writeback) begin
        r_regs[r_rd] <= r_res;
      end
      if (w_accept) begin
        r_mode <= in_instr[15:12];
        r_rd   <= in_instr[11:9];
        r_ra   <= in_instr[8:6];
        r_rb   <= in_instr[5:3];
        r_wb   <= in_instr[2];
      end
      if (r_state == ISSUE) begin
        r_res   <= alu_out;
        r_flags <= alu_flags;
      end
      // Flags land only at retire, so the status never reflects an unfinished instruction.
      if (r_state == WRITE) begin
        r_status <= r_flags;
      end
    end
  end

endmodule
